// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer: op encodings, FSM states
// and the op-mapping helper that turns set-less-than into an ALU subtract.
package alu_seq_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    HOLD
  } state_t;

  // SLT is computed by the ALU as a subtract; its answer comes from the set flag.
  function automatic logic [2:0] map_op(input logic [2:0] op);
    return (op == OP_SLT) ? OP_SUB : op;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request, ALU-drive and response channels of the ALU sequencer.
// master is the sequencer's view; slave is the requester/ALU/consumer side.
interface alu_seq_if
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_cout;
  logic             alu_zero;
  logic             alu_set;
  logic             alu_overflow;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_cout;
  logic             rsp_zero;
  logic             rsp_set;
  logic             rsp_overflow;

  modport master (
    input  req_valid, req_op, req_a, req_b,
    input  alu_result, alu_cout, alu_zero, alu_set, alu_overflow,
    input  rsp_ready,
    output req_ready,
    output alu_a, alu_b, alu_op,
    output rsp_valid, rsp_result, rsp_cout, rsp_zero, rsp_set, rsp_overflow
  );

  modport slave (
    output req_valid, req_op, req_a, req_b,
    output alu_result, alu_cout, alu_zero, alu_set, alu_overflow,
    output rsp_ready,
    input  req_ready,
    input  alu_a, alu_b, alu_op,
    input  rsp_valid, rsp_result, rsp_cout, rsp_zero, rsp_set, rsp_overflow
  );

endinterface

// File: rtl/alu_settle_timer.sv
// Settle-time counter: loads on request accept, counts down to zero and stops
// there; done is high while the count is zero.
module alu_settle_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  // NOTE: non-blocking assignments for every register so all of them sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_value;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Drives a combinational ALU from a valid/ready request, waits SETTLE cycles,
// then returns the captured result/flags. ALU_SEQ_STICKY_OVF_EN adds a sticky overflow bit.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 4
) (
  input  logic      clk,
  input  logic      rst,
  alu_seq_if.master bus,
`ifdef ALU_SEQ_STICKY_OVF_EN
  input  logic      ovf_clr,
  output logic      ovf_sticky,
`endif
  output logic      busy
);

  state_t     state;
  logic [2:0] op_q;
  logic       timer_load;
  logic       timer_done;
  logic       capture;

  assign timer_load    = (state == IDLE) && bus.req_valid;
  assign capture       = (state == DRIVE) && timer_done;
  assign bus.req_ready = (state == IDLE);
  assign busy          = (state != IDLE);

  alu_settle_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (CNT_W'(SETTLE - 1)),
    .dec        (state == DRIVE),
    .done       (timer_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      op_q             <= '0;
      bus.alu_a        <= '0;
      bus.alu_b        <= '0;
      bus.alu_op       <= '0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_result   <= '0;
      bus.rsp_cout     <= 1'b0;
      bus.rsp_zero     <= 1'b0;
      bus.rsp_set      <= 1'b0;
      bus.rsp_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            bus.alu_a  <= bus.req_a;
            bus.alu_b  <= bus.req_b;
            bus.alu_op <= map_op(bus.req_op);
            op_q       <= bus.req_op;
            state      <= DRIVE;
          end
        end
        DRIVE: begin
          if (capture) begin
            bus.rsp_result   <= (op_q == OP_SLT) ? {{(WIDTH-1){1'b0}}, bus.alu_set}
                                                 : bus.alu_result;
            bus.rsp_cout     <= bus.alu_cout;
            bus.rsp_zero     <= bus.alu_zero;
            bus.rsp_set      <= bus.alu_set;
            bus.rsp_overflow <= bus.alu_overflow;
            bus.rsp_valid    <= 1'b1;
            state            <= HOLD;
          end
        end
        HOLD: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_STICKY_OVF_EN
  // Set has priority over clear when both land on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
    end else if (capture && bus.alu_overflow &&
                 ((op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_SLT))) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural 32-bit ALU on the drive side.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  logic clk;
  logic rst;
  logic busy;
`ifdef ALU_SEQ_STICKY_OVF_EN
  logic ovf_clr;
  logic ovf_sticky;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  alu_seq_if #(.WIDTH(32)) bus ();

  alu_sequencer #(
    .WIDTH  (32),
    .SETTLE (2),
    .CNT_W  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
`ifdef ALU_SEQ_STICKY_OVF_EN
    .ovf_clr    (ovf_clr),
    .ovf_sticky (ovf_sticky),
`endif
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: and/or/add/sub, anything else returns a^b.
  logic [32:0] m_sum;
  logic [31:0] m_res;
  logic        m_cout;
  logic        m_ovf;
  logic        m_arith;

  always_comb begin
    m_sum   = 33'd0;
    m_res   = bus.alu_a ^ bus.alu_b;
    m_cout  = 1'b0;
    m_ovf   = 1'b0;
    m_arith = 1'b0;
    case (bus.alu_op)
      3'b000: m_res = bus.alu_a & bus.alu_b;
      3'b001: m_res = bus.alu_a | bus.alu_b;
      3'b010: begin
        m_sum   = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        m_res   = m_sum[31:0];
        m_cout  = m_sum[32];
        m_ovf   = (bus.alu_a[31] == bus.alu_b[31]) && (m_sum[31] != bus.alu_a[31]);
        m_arith = 1'b1;
      end
      3'b110: begin
        m_sum   = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 33'd1;
        m_res   = m_sum[31:0];
        m_cout  = m_sum[32];
        m_ovf   = (bus.alu_a[31] != bus.alu_b[31]) && (m_sum[31] != bus.alu_a[31]);
        m_arith = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.alu_result   = m_res;
  assign bus.alu_cout     = m_cout;
  assign bus.alu_overflow = m_ovf;
  assign bus.alu_zero     = (m_res == 32'd0);
  assign bus.alu_set      = m_arith & (m_res[31] ^ m_ovf);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Present one request and follow it until rsp_valid (bounded); called with the DUT idle.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       output int lat, output logic [2:0] op_seen, output bit held);
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_op    = op;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    op_seen = bus.alu_op;
    held    = 1'b1;
    lat     = 0;
    while (!bus.rsp_valid && lat < 40) begin
      if (bus.alu_op !== op_seen || bus.alu_a !== a || bus.alu_b !== b) held = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0 || bus.alu_op !== 3'd0) begin
      n_fail++; $display("FAIL reset_alu: got a=%h b=%h op=%b want all 0", bus.alu_a, bus.alu_b, bus.alu_op); end
    n_checks++; if (bus.rsp_result !== 32'd0 || bus.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_rsp: got result=%h valid=%b want 0/0", bus.rsp_result, bus.rsp_valid); end
    n_checks++; if ({bus.rsp_cout, bus.rsp_zero, bus.rsp_set, bus.rsp_overflow} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", {bus.rsp_cout, bus.rsp_zero, bus.rsp_set, bus.rsp_overflow}); end
    n_checks++; if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
`ifdef ALU_SEQ_STICKY_OVF_EN
    n_checks++; if (ovf_sticky !== 1'b0) begin
      n_fail++; $display("FAIL reset_sticky: got %b want 0", ovf_sticky); end
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_checks++; if (bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    int lat; logic [2:0] ops; bit held;
    issue(32'd7, 32'd5, OP_ADD, lat, ops, held);
    n_checks++; if (ops !== 3'b010 || !held) begin
      n_fail++; $display("FAIL add_alu_drive: got op=%b held=%0d want 010 held=1", ops, held); end
    n_checks++; if (lat !== 2) begin
      n_fail++; $display("FAIL add_latency: got %0d edges want 2", lat); end
    n_checks++; if (bus.rsp_result !== 32'd12) begin
      n_fail++; $display("FAIL add_result: got %h want %h", bus.rsp_result, 32'd12); end
    n_checks++; if ({bus.rsp_cout, bus.rsp_zero, bus.rsp_overflow} !== 3'b000) begin
      n_fail++; $display("FAIL add_flags: got cout/zero/ovf=%b want 000", {bus.rsp_cout, bus.rsp_zero, bus.rsp_overflow}); end
    n_checks++; if (bus.req_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL add_hold_state: got req_ready=%b busy=%b want 0/1", bus.req_ready, busy); end
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL add_return_idle: got busy=%b valid=%b ready=%b want 0/0/1", busy, bus.rsp_valid, bus.req_ready); end
  endtask

  task automatic test_sub();
    int lat; logic [2:0] ops; bit held;
    issue(32'd5, 32'd7, OP_SUB, lat, ops, held);
    n_checks++; if (bus.rsp_result !== 32'hFFFF_FFFE || bus.rsp_set !== 1'b1 || bus.rsp_zero !== 1'b0) begin
      n_fail++; $display("FAIL sub_neg: got result=%h set=%b zero=%b want fffffffe/1/0", bus.rsp_result, bus.rsp_set, bus.rsp_zero); end
    wait_idle();
    issue(32'd9, 32'd9, OP_SUB, lat, ops, held);
    n_checks++; if (bus.rsp_result !== 32'd0 || bus.rsp_zero !== 1'b1 || bus.rsp_cout !== 1'b1) begin
      n_fail++; $display("FAIL sub_zero: got result=%h zero=%b cout=%b want 0/1/1", bus.rsp_result, bus.rsp_zero, bus.rsp_cout); end
    wait_idle();
  endtask

  task automatic test_slt();
    int lat; logic [2:0] ops; bit held;
    issue(32'd3, 32'd9, OP_SLT, lat, ops, held);
    n_checks++; if (ops !== 3'b110 || !held) begin
      n_fail++; $display("FAIL slt_alu_op: got op=%b held=%0d want 110 held=1", ops, held); end
    n_checks++; if (bus.rsp_result !== 32'd1 || bus.rsp_set !== 1'b1) begin
      n_fail++; $display("FAIL slt_true: got result=%h set=%b want 1/1", bus.rsp_result, bus.rsp_set); end
    wait_idle();
    issue(32'd9, 32'd3, OP_SLT, lat, ops, held);
    n_checks++; if (bus.rsp_result !== 32'd0) begin
      n_fail++; $display("FAIL slt_false: got result=%h want 0", bus.rsp_result); end
    wait_idle();
  endtask

  task automatic test_passthrough();
    int lat; logic [2:0] ops; bit held;
    issue(32'hF0F0_0000, 32'h0000_0F0F, OP_OR, lat, ops, held);
    n_checks++; if (ops !== 3'b001 || bus.rsp_result !== 32'hF0F0_0F0F) begin
      n_fail++; $display("FAIL or_result: got op=%b result=%h want 001/f0f00f0f", ops, bus.rsp_result); end
    wait_idle();
    issue(32'hFF00_FF00, 32'h0FF0_0FF0, 3'b011, lat, ops, held);
    n_checks++; if (ops !== 3'b011 || bus.rsp_result !== 32'hF0F0_F0F0) begin
      n_fail++; $display("FAIL other_op: got op=%b result=%h want 011/f0f0f0f0", ops, bus.rsp_result); end
    wait_idle();
  endtask

  task automatic test_overflow();
    int lat; logic [2:0] ops; bit held;
    issue(32'h7FFF_FFFF, 32'd1, OP_ADD, lat, ops, held);
    n_checks++; if (bus.rsp_result !== 32'h8000_0000 || bus.rsp_overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_add: got result=%h ovf=%b want 80000000/1", bus.rsp_result, bus.rsp_overflow); end
`ifdef ALU_SEQ_STICKY_OVF_EN
    n_checks++; if (ovf_sticky !== 1'b1) begin
      n_fail++; $display("FAIL ovf_sticky_set: got %b want 1", ovf_sticky); end
`endif
    wait_idle();
`ifdef ALU_SEQ_STICKY_OVF_EN
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    n_checks++; if (ovf_sticky !== 1'b0) begin
      n_fail++; $display("FAIL ovf_sticky_clear: got %b want 0", ovf_sticky); end
    // Clear pulsed on the capture edge of a second overflowing add.
    bus.req_a = 32'h7FFF_FFFF; bus.req_b = 32'd1; bus.req_op = OP_ADD; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    n_checks++; if (ovf_sticky !== 1'b1 || bus.rsp_valid !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set_wins: got sticky=%b valid=%b want 1/1", ovf_sticky, bus.rsp_valid); end
    wait_idle();
`endif
  endtask

  task automatic test_backpressure();
    int lat; logic [2:0] ops; bit held; bit stable;
    bus.rsp_ready = 1'b0;
    issue(32'h100, 32'h23, OP_ADD, lat, ops, held);
    n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 32'h123) begin
      n_fail++; $display("FAIL bp_first: got valid=%b result=%h want 1/123", bus.rsp_valid, bus.rsp_result); end
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.req_a = 32'hDEAD; bus.req_b = 32'hBEEF; bus.req_op = OP_AND; bus.req_valid = 1'b1;
      @(posedge clk); #1;
      if (bus.rsp_result !== 32'h123 || bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0 ||
          bus.alu_a !== 32'h100 || bus.alu_op !== OP_ADD) stable = 1'b0;
    end
    n_checks++; if (!stable) begin
      n_fail++; $display("FAIL bp_stable: got result=%h valid=%b ready=%b alu_a=%h want 123/1/0/100",
                         bus.rsp_result, bus.rsp_valid, bus.req_ready, bus.alu_a); end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.alu_a !== 32'h100) begin
      n_fail++; $display("FAIL bp_release: got busy=%b valid=%b alu_a=%h want 0/0/100", busy, bus.rsp_valid, bus.alu_a); end
  endtask

  task automatic test_back_to_back();
    int acc[2];
    int n_acc = 0;
    bit prev_busy;
    bit early = 1'b0;
    prev_busy = busy;
    bus.req_a = 32'd1; bus.req_b = 32'd1; bus.req_op = OP_ADD; bus.req_valid = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(posedge clk); #1;
      if (busy && !prev_busy && n_acc < 2) begin
        acc[n_acc] = cyc;
        n_acc++;
      end
      if (cyc == 4 && busy) early = 1'b1;
      prev_busy = busy;
    end
    bus.req_valid = 1'b0;
    n_checks++; if (n_acc != 2 || early) begin
      n_fail++; $display("FAIL b2b_accepts: got %0d accepts early=%0d want 2/0", n_acc, early); end
    n_checks++; if (n_acc == 2 && (acc[1] - acc[0]) != 4) begin
      n_fail++; $display("FAIL b2b_spacing: got %0d edges want 4", acc[1] - acc[0]); end
    wait_idle();
  endtask

  task automatic test_reset_in_drive();
    int lat; logic [2:0] ops; bit held; bit seen = 1'b0;
    bus.req_a = 32'hAAAA; bus.req_b = 32'h5555; bus.req_op = OP_ADD; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0 || bus.alu_op !== 3'd0 || busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_drive_async: got a=%h b=%h op=%b busy=%b valid=%b want all 0",
                         bus.alu_a, bus.alu_b, bus.alu_op, busy, bus.rsp_valid); end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_checks++; if (bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_drive_ready: got %b want 1", bus.req_ready); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid !== 1'b0) seen = 1'b1;
    end
    n_checks++; if (seen) begin
      n_fail++; $display("FAIL rst_drive_no_rsp: got rsp_valid=1 want 0"); end
    issue(32'd2, 32'd3, OP_ADD, lat, ops, held);
    n_checks++; if (lat !== 2 || bus.rsp_result !== 32'd5) begin
      n_fail++; $display("FAIL rst_drive_next: got lat=%0d result=%h want 2/5", lat, bus.rsp_result); end
    wait_idle();
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_a     = 32'd0;
    bus.req_b     = 32'd0;
    bus.rsp_ready = 1'b1;
`ifdef ALU_SEQ_STICKY_OVF_EN
    ovf_clr       = 1'b0;
`endif
    test_reset();
    test_add();
    test_sub();
    test_slt();
    test_passthrough();
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_reset_in_drive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
